// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one external 8-bit
// combinational adder between NUM_REQ requesters and returns the registered
// sum plus requester ID on a single backpressured response channel.
// Optional build macro ADDER_ARB_STATS_EN adds a 16-bit handshake counter
// output (op_count).
module adder_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [7:0]           add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_sum,
`ifdef ADDER_ARB_STATS_EN
    output logic [15:0]          op_count,
`endif
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // NUM_REQ expressed one bit wider than an ID so wrap arithmetic never overflows
    localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_sum_q, rsp_sum_d;

    logic            any_valid;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] rr_next;
    logic            slot_free;
    logic            handshake;

    assign slot_free = !rsp_valid_q || rsp_ready;
    assign handshake = rsp_valid_q && rsp_ready;

    // Round-robin search: first valid requester at or above rr_ptr, with wrap
    always_comb begin
        logic [ID_W:0] cand;
        any_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
                any_valid = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Pointer value following the granted requester, wrapping at NUM_REQ
    always_comb begin
        logic [ID_W:0] nxt;
        nxt = {1'b0, gnt_idx} + (ID_W+1)'(1);
        if (nxt >= NREQ_W) begin
            nxt = '0;
        end
        rr_next = nxt[ID_W-1:0];
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant from IDLE, then retire once the response slot frees
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = slot_free ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (slot_free) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: one-hot accept in IDLE only, adder operands while busy
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid && !wb_rst_i) begin
                    req_ready[gnt_idx] = 1'b1;
                end
            end
            ST_EXEC, ST_WAIT: begin
                add_a = op_a_q;
                add_b = op_b_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: operand capture on grant, response load/clear
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        gid_d       = gid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        // a handshake empties the slot unless a new result lands below
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        if (state_q == ST_IDLE && any_valid) begin
            op_a_d   = req_a[{gnt_idx, 3'b000} +: 8];
            op_b_d   = req_b[{gnt_idx, 3'b000} +: 8];
            gid_d    = gnt_idx;
            rr_ptr_d = rr_next;
        end
        if (state_q != ST_IDLE && slot_free) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gid_q;
            rsp_sum_d   = add_sum;
        end
    end

    // Datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rr_ptr_q    <= '0;
            gid_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            gid_q       <= gid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q;

    // Completed-handshake counter, wraps naturally at 16 bits
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_count_q <= '0;
        end else if (handshake) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           add_a;
    logic [7:0]           add_b;
    logic [7:0]           add_sum;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_sum;
    logic                 busy;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]          op_count;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    // the shared external adder
    assign add_sum = add_a + add_b;

    adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
`ifdef ADDER_ARB_STATS_EN
        .op_count (op_count),
`endif
        .busy     (busy)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = '1;
        req_a     = $urandom;
        req_b     = $urandom;
        rsp_ready = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
        vectors++; if (rsp_sum !== 8'h00) begin errors++; $display("FAIL rst_rsp_sum: got %h expected 00", rsp_sum); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if ({add_a, add_b} !== 16'h0) begin errors++; $display("FAIL rst_add_ops: got %h expected 0000", {add_a, add_b}); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: got %b expected 0001", req_ready); end
    endtask

    task automatic test_reset_mid_exec;
        logic [7:0] a0, b0;
        do_reset();
        rsp_ready = 1'b1;
        set_ops(0, 8'h10, 8'h20);
        req_valid = 4'b0001;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_exec_busy: got %b expected 1", busy); end
        #1 rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
            next_cycle();
        end
        a0 = 8'($urandom); b0 = 8'($urandom);
        set_ops(0, a0, b0);
        req_valid = 4'b1111;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 8'(a0 + b0)}) begin
            errors++; $display("FAIL mid_after_rsp: got v%b id%0d %h expected v1 id0 %h", rsp_valid, rsp_id, rsp_sum, 8'(a0 + b0));
        end
    endtask

    task automatic test_single;
        do_reset();
        rsp_ready = 1'b1;
        set_ops(1, 8'h12, 8'h34);
        req_valid = 4'b0010;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        vectors++; if ({busy, req_ready, rsp_valid} !== 6'b1_0000_0) begin
            errors++; $display("FAIL single_exec: got busy%b ready%b v%b expected busy1 ready0000 v0", busy, req_ready, rsp_valid);
        end
        vectors++; if ({add_a, add_b} !== 16'h1234) begin errors++; $display("FAIL single_add_ops: got %h expected 1234", {add_a, add_b}); end
        next_cycle();
        @(negedge clk);
        vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 8'h46}) begin
            errors++; $display("FAIL single_rsp: got v%b id%0d %h expected v1 id1 46", rsp_valid, rsp_id, rsp_sum);
        end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        next_cycle();
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_wrap;
        logic [7:0] ta [3] = '{8'hFF, 8'h80, 8'h7F};
        logic [7:0] tb [3] = '{8'h01, 8'h80, 8'h7F};
        logic [7:0] ts [3] = '{8'h00, 8'h00, 8'hFE};
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_ops(0, ta[i], tb[i]);
            req_valid = 4'b0001;
            @(negedge clk);
            vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready%0d: got %b expected 0001", i, req_ready); end
            next_cycle();
            req_valid = '0;
            next_cycle();
            @(negedge clk);
            vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, ts[i]}) begin
                errors++; $display("FAIL wrap_sum%0d: got v%b id%0d %h expected v1 id0 %h", i, rsp_valid, rsp_id, rsp_sum, ts[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_all_valid;
        logic [7:0] oa [NUM_REQ];
        logic [7:0] ob [NUM_REQ];
        int         waited;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            oa[i] = 8'($urandom); ob[i] = 8'($urandom);
            set_ops(i, oa[i], ob[i]);
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        waited = 0;
        @(negedge clk);
        while (!rsp_valid && waited < 10) begin
            next_cycle();
            @(negedge clk);
            waited++;
        end
        vectors++; if (waited != 2) begin errors++; $display("FAIL allv_latency: got %0d cycles expected 2", waited); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'(i % NUM_REQ), 8'(oa[i % NUM_REQ] + ob[i % NUM_REQ])}) begin
                errors++; $display("FAIL allv_rsp%0d: got v%b id%0d %h expected v1 id%0d %h", i, rsp_valid, rsp_id, rsp_sum,
                                   i % NUM_REQ, 8'(oa[i % NUM_REQ] + ob[i % NUM_REQ]));
            end
            next_cycle();
            @(negedge clk);
            vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL allv_gap%0d: got %b expected 0", i, rsp_valid); end
            next_cycle();
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        logic [7:0] a2, b2, a3, b3;
        do_reset();
        a2 = 8'($urandom); b2 = 8'($urandom); a3 = 8'($urandom); b3 = 8'($urandom);
        set_ops(2, a2, b2);
        set_ops(3, a3, b3);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        vectors++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b expected 0100", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd2, 8'(a2 + b2)}) begin
            errors++; $display("FAIL bp_first_rsp: got v%b id%0d %h expected v1 id2 %h", rsp_valid, rsp_id, rsp_sum, 8'(a2 + b2));
        end
        req_valid = 4'b1000;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b expected 1000", req_ready); end
        next_cycle();
        req_valid = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if ({busy, req_ready} !== 5'b1_0000) begin
                errors++; $display("FAIL bp_wait%0d: got busy%b ready%b expected busy1 ready0000", c, busy, req_ready);
            end
            vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd2, 8'(a2 + b2)}) begin
                errors++; $display("FAIL bp_hold%0d: got v%b id%0d %h expected v1 id2 %h", c, rsp_valid, rsp_id, rsp_sum, 8'(a2 + b2));
            end
            vectors++; if ({add_a, add_b} !== {a3, b3}) begin
                errors++; $display("FAIL bp_ops%0d: got %h expected %h", c, {add_a, add_b}, {a3, b3});
            end
            next_cycle();
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        next_cycle();
        rsp_ready = 1'b0;
        @(negedge clk);
        vectors++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd3, 8'(a3 + b3)}) begin
            errors++; $display("FAIL bp_second_rsp: got v%b id%0d %h expected v1 id3 %h", rsp_valid, rsp_id, rsp_sum, 8'(a3 + b3));
        end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy); end
    endtask

    // Transaction-level model: one operation outstanding at most, a single
    // response slot, and a rotating priority pointer.
    task automatic test_random;
        bit         m_inflight = 0;
        int         m_pid = 0;
        logic [7:0] m_pa = 0, m_pb = 0;
        bit         m_slot_v = 0;
        int         m_slot_id = 0;
        logic [7:0] m_slot_sum = 0;
        int         m_rr = 0;
        int         pick;
        logic [NUM_REQ-1:0] exp_ready;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : NUM_REQ'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            pick = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (pick < 0 && req_valid[(m_rr + k) % NUM_REQ]) pick = (m_rr + k) % NUM_REQ;
            end
            exp_ready = (!m_inflight && pick >= 0) ? NUM_REQ'(1 << pick) : '0;
            vectors++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, req_ready, exp_ready); end
            vectors++; if (busy !== m_inflight) begin errors++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, m_inflight); end
            vectors++; if (rsp_valid !== m_slot_v) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, rsp_valid, m_slot_v); end
            if (m_slot_v) begin
                vectors++; if ({rsp_id, rsp_sum} !== {2'(m_slot_id), m_slot_sum}) begin
                    errors++; $display("FAIL rnd_rsp@%0d: got id%0d %h expected id%0d %h", c, rsp_id, rsp_sum, m_slot_id, m_slot_sum);
                end
            end
            vectors++; if ({add_a, add_b} !== (m_inflight ? {m_pa, m_pb} : 16'h0)) begin
                errors++; $display("FAIL rnd_ops@%0d: got %h expected %h", c, {add_a, add_b}, m_inflight ? {m_pa, m_pb} : 16'h0);
            end
            // advance the model across the coming edge
            if (m_inflight) begin
                if (!m_slot_v || rsp_ready) begin
                    m_slot_v   = 1;
                    m_slot_id  = m_pid;
                    m_slot_sum = 8'((int'(m_pa) + int'(m_pb)) % 256);
                    m_inflight = 0;
                end
            end else begin
                if (m_slot_v && rsp_ready) m_slot_v = 0;
                if (pick >= 0) begin
                    m_inflight = 1;
                    m_pid      = pick;
                    m_pa       = req_a[8*pick +: 8];
                    m_pb       = req_b[8*pick +: 8];
                    m_rr       = (pick + 1) % NUM_REQ;
                end
            end
            next_cycle();
        end
        req_valid = '0;
    endtask

`ifdef ADDER_ARB_STATS_EN
    task automatic test_stats;
        do_reset();
        @(negedge clk);
        vectors++; if (op_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", op_count); end
        next_cycle();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_ops(0, 8'($urandom), 8'($urandom));
            req_valid = 4'b0001;
            next_cycle();
            req_valid = '0;
            next_cycle();
            next_cycle();
        end
        @(negedge clk);
        vectors++; if (op_count !== 16'd5) begin errors++; $display("FAIL stats_five: got %0d expected 5", op_count); end
        next_cycle();
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        #1;
        vectors++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL stats_preset: got %h expected ffff", op_count); end
        req_valid = 4'b0001;
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        vectors++; if (op_count !== 16'h0000) begin errors++; $display("FAIL stats_wrap: got %h expected 0000", op_count); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_single();
        test_wrap();
        test_all_valid();
        test_backpressure();
        test_random();
`ifdef ADDER_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 8-bit combinational adder (modulo-256 sum, no carry) between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter grants one requester, drives the shared adder from registered operands, and returns the registered sum with the requester ID on a single response channel with backpressure.
- Sits between user-project logic clients and the single adder instance in the Caravel user area.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must equal clog2(NUM_REQ).

Ports:
- wb_clk_i  input  1  clock; all state changes on the rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_a  input  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i].
- req_b  input  NUM_REQ*8  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept, combinational.
- add_a  output  8  operand A to the shared adder.
- add_b  output  8  operand B to the shared adder.
- add_sum  input  8  sum returned by the shared adder, combinational from add_a/add_b.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns rsp_sum.
- rsp_sum  output  8  registered sum.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high wb_rst_i): state=IDLE, rr_ptr=0, operand regs=0, rsp_valid=0, rsp_id=0, rsp_sum=0. req_ready=0 while reset is asserted.
- Reset during EXEC or WAIT discards the in-flight operation; no response is produced for it.
- States:
  - IDLE: add_a=add_b=0. If any req_valid bit is set, grant the first set bit found searching upward from rr_ptr with wrap. req_ready[g]=1 for that bit only, in the same cycle. On that edge: capture a/b into operand regs, gid=g, rr_ptr=(g+1)%NUM_REQ, go to EXEC. If no req_valid bit is set, stay in IDLE and leave rr_ptr unchanged.
  - EXEC: add_a/add_b come from the operand regs; req_ready=0. If the response slot is free (rsp_valid==0, or rsp_ready==1 this cycle): on the edge, rsp_sum=add_sum, rsp_id=gid, rsp_valid=1, go to IDLE. Otherwise go to WAIT.
  - WAIT: operands stay driven; req_ready=0. When the slot frees, load the response as in EXEC and go to IDLE.
- Response slot:
  - rsp_valid, rsp_id and rsp_sum hold stable until the rsp_valid&&rsp_ready handshake.
  - rsp_valid clears on the handshake edge unless a new result loads on the same edge, in which case it stays 1 with the new data.
- Latency: accept at edge N -> rsp_valid visible after edge N+1.
- Throughput: one operation per 2 cycles with no backpressure.
- Arithmetic: the sum is add_sum unmodified (mod 256); overflow is silently dropped.
- A requester may drop req_valid before it is granted; no acceptance occurs and no error is flagged.
- At most one req_ready bit is high in any cycle. req_ready never asserts outside IDLE.
- Fairness: no requester waits more than NUM_REQ grants while it holds req_valid.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- Defined: adds output op_count [15:0].
  - Reset to 0.
  - Increments on each rsp_valid&&rsp_ready handshake.
  - Wraps 0xFFFF -> 0x0000.
- Undefined: op_count port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-EXEC, with req0 accepted a=0x10 b=0x20: after release, no response appears, rsp_valid=0, rr_ptr=0, and the next grant goes to req0 if valid.
- Single request: req1 a=0x12 b=0x34 with rsp_ready=1 -> req_ready=0b0010 for one cycle; rsp_valid=1 with rsp_id=1, rsp_sum=0x46 after edge N+1; busy high for exactly one cycle.
- Wrap-around: req0 a=0xFF b=0x01 -> rsp_sum=0x00. Then a=0x80 b=0x80 -> rsp_sum=0x00. Then a=0x7F b=0x7F -> 0xFE.
- All four valid, held continuously, rsp_ready=1: rsp_id sequence is 0,1,2,3,0,1; one response every 2 cycles; each rsp_sum matches its own operands.
- Backpressure: rsp_ready=0 with one response pending and a second op in flight -> FSM enters WAIT, rsp_* stays stable, and no req_ready asserts. When rsp_ready rises, the second result loads on the handshake edge with rsp_valid held at 1.
- With ADDER_ARB_STATS_EN: complete 5 handshakes -> op_count=5. Force op_count to 0xFFFF, complete one more handshake -> op_count=0x0000.
